udp_tx_arbiter: RTL and testbench
=================================

Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit path of gmii2udp among NREQ port handlers (udpecho, udpstatic, udpcnt, udplb64, ...), using round-robin selection and one frame at a time.
- Sits between the port handlers' tx side and the shared udplink tx side. The rx path stays with udpsw.
- Sequences request, start, byte stream and done for each frame. A watchdog recovers the link from a stalled requester or MAC.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LENW, 16, frame length width in bytes.
- TIMEOUT, 65535, max cycles spent in S_REQ or S_XFER before abort; 0 disables the watchdog.

Ports:
- clk  in  1  ethernet tx clock (ethclk).
- reset  in  1  synchronous, active-high.
- req  in  NREQ  per-requester frame request; held until done pulse.
- req_len  in  NREQ*LENW  per-requester payload length, slice i at [i*LENW+:LENW]; stable while req[i] is high.
- req_port  in  NREQ*16  per-requester UDP source port.
- req_data  in  NREQ*8  per-requester payload byte; valid the cycle after rd[i].
- rd  out  NREQ  byte strobe to the granted requester (one-hot or zero).
- done  out  NREQ  one-cycle completion pulse to a requester.
- grant  out  NREQ  one-hot current owner.
- link_req  out  1  frame request to the shared tx link.
- link_len  out  LENW  length of the granted frame.
- link_port  out  16  source port of the granted frame.
- link_start  in  1  link accepted the request (one cycle).
- link_rd  in  1  link byte strobe.
- link_data  out  8  byte muxed from the granted requester.
- link_done  in  1  link finished the frame (one cycle).
- err  out  1  one-cycle pulse on watchdog abort.
- frame_cnt  out  32  completed frames, wraps.

Behaviour:
- Reset values: all outputs 0, state S_IDLE, rr pointer 0, watchdog 0.
- **S_IDLE**
  - If req != 0, pick the first set bit searching from ptr upward, with wrap modulo NREQ.
  - Register the winner into grant, latch link_len and link_port, then go to S_REQ.
  - Decision latency: 1 cycle from req to grant.
- **Zero-length request:** if the winner's req_len == 0, do not assert link_req.
  - Pulse done[winner] the next cycle, advance ptr, return to S_IDLE.
  - frame_cnt is not incremented.
- **S_REQ**
  - Hold link_req = 1.
  - On link_start: drop link_req, go to S_XFER.
- **S_XFER**
  - rd = grant & {NREQ{link_rd}}, combinational.
  - link_data = req_data slice of the granted requester, combinational mux. The 1-cycle data latency is therefore the requester's latency.
  - On link_done: pulse done[grant], clear grant, ptr = winner+1 mod NREQ, frame_cnt += 1, return to S_IDLE.
- **Next arbitration:** earliest one cycle after done. A requester that keeps req high is re-eligible but loses priority to the others.
- **Fairness:** with all NREQ requesting continuously, grants rotate 0,1,..,NREQ-1,0 strictly.
- **Request changes:**
  - A req bit dropping during the winner's own frame is ignored; the frame completes.
  - A req bit dropping while that requester is not granted simply removes it from arbitration.
- **Watchdog:**
  - Counter clears on each state entry and on each link_rd.
  - If it reaches TIMEOUT in S_REQ or S_XFER: pulse err, pulse done[grant], clear link_req and grant, advance ptr, go to S_IDLE.
  - frame_cnt is not incremented on abort.
- **Simultaneous events:**
  - link_start and link_done in the same cycle in S_REQ: treat as start then done, i.e. complete the frame.
  - link_done seen in S_IDLE or S_REQ without start: ignored.
- **reset:** reset in mid-frame forces all outputs to 0 the next cycle with no done pulse. The requester must re-request.

Decomposition:
- Shared package udp_arb_pkg holds:
  - state enum {S_IDLE, S_REQ, S_XFER};
  - LENW default;
  - rr-pick function (mask-and-priority with wrap).
- One sub-module: rr_pick. It is combinational, NREQ-wide, takes req and ptr and returns a one-hot winner plus a valid flag. The FSM, muxes, watchdog and counter stay in the top module.

Test Plan:
- Single frame:
  - Stimulus: req=4'b0010, len=4, port=16'hd001; link_start 3 cycles after link_req; 4 link_rd strobes; then link_done.
  - Response: link_len=4, link_port=16'hd001, rd[1] strobes 4 times, link_data tracks req_data[15:8], done[1] pulses once, frame_cnt=1.
- Round-robin:
  - Stimulus: req=4'b1111 held; each frame 2 bytes.
  - Response: grant order 0,1,2,3,0; 5 done pulses; frame_cnt=5.
- Priority rotation:
  - Stimulus: req[0] and req[2] held.
  - Response: grants alternate 0,2,0,2; requester 0 never gets two consecutive grants.
- Zero length:
  - Stimulus: req[3], len=0.
  - Response: link_req never asserted; done[3] 2 cycles after req; frame_cnt unchanged.
- Watchdog:
  - Setup: TIMEOUT=16.
  - Stimulus: link_start, then no link_rd or link_done.
  - Response: err pulses 16 cycles after entering S_XFER; done[grant] pulses; next requester granted; frame_cnt unchanged.
- Reset mid-frame:
  - Stimulus: assert reset during S_XFER.
  - Response: next cycle grant=0, link_req=0, rd=0, no done/err; after release, normal arbitration restarts from ptr 0.

Source files
------------

// File: rtl/udp_arb_pkg.sv
// Shared definitions for the UDP transmit arbiter: FSM states, the default
// length width and the round-robin search used by rr_pick.
package udp_arb_pkg;
  localparam int LENW_DEF = 16;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  // Index of the first set bit of req[n-1:0], searching upward from ptr with
  // wrap modulo n; -1 when nothing is set. Works for n up to 8. Offsets are
  // scanned from high to low so the smallest offset is the last to land.
  function automatic int rr_first(input logic [7:0] req, input int ptr, input int n);
    int k;
    rr_first = -1;
    for (int off = 7; off >= 0; off--) begin
      if (off < n) begin
        k = (ptr + off) % n;
        if (req[k]) rr_first = k;
      end
    end
  endfunction
endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : index that has highest priority this round
//   win : one-hot winner (zero when no request)
//   idx : binary index of the winner
//   vld : at least one request present
module rr_pick
  import udp_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   idx,
  output logic            vld
);
  always_comb begin
    int k;
    k   = rr_first(8'(req), int'(ptr), NREQ);
    vld = (k >= 0);
    win = '0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (k == i) begin
        win[i] = 1'b1;
        idx    = PW'(i);
      end
    end
  end
endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP tx link among NREQ port handlers,
// one frame at a time, with a watchdog that aborts stalled frames.
//   clk/reset            : tx clock, synchronous active-high reset
//   req/req_len/req_port : per-requester frame request, length, source port
//   req_data             : per-requester byte, valid the cycle after rd
//   rd/done/grant        : byte strobe, completion pulse, one-hot owner
//   link_*               : shared tx link handshake and byte path
//   err                  : pulse on watchdog abort
//   frame_cnt            : completed frames (wraps)
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LENW    = LENW_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LENW-1:0] req_len,
  input  logic [NREQ*16-1:0]   req_port,
  input  logic [NREQ*8-1:0]    req_data,
  output logic [NREQ-1:0]      rd,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      grant,
  output logic                 link_req,
  output logic [LENW-1:0]      link_len,
  output logic [15:0]          link_port,
  input  logic                 link_start,
  input  logic                 link_rd,
  output logic [7:0]           link_data,
  input  logic                 link_done,
  output logic                 err,
  output logic [31:0]          frame_cnt
);
  localparam int PW = $clog2(NREQ);

  state_t          state, state_nx;
  logic [PW-1:0]   ptr, gidx, pick_idx;
  logic [NREQ-1:0] pick_win;
  logic            pick_vld;
  logic [31:0]     wd;
  logic            wd_hit, take, fin, abort, zdone;
  logic [LENW-1:0] sel_len;
  logic [15:0]     sel_port;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (pick_win),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_comb begin
    sel_len  = '0;
    sel_port = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_win[i]) begin
        sel_len  = req_len[i*LENW +: LENW];
        sel_port = req_port[i*16 +: 16];
      end
    end
  end

  // Watchdog fires on the cycle the count would reach TIMEOUT, so err is
  // visible exactly TIMEOUT cycles after state entry / last link_rd.
  assign wd_hit = (TIMEOUT != 0) && (wd == 32'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    fin      = 1'b0;
    abort    = 1'b0;
    zdone    = 1'b0;
    case (state)
      S_IDLE: if (pick_vld) begin
        take     = 1'b1;
        state_nx = S_REQ;
      end
      S_REQ: begin
        if (link_len == '0) begin
          zdone    = 1'b1;
          state_nx = S_IDLE;
        end else if (link_start && link_done) begin
          // start and done together: the frame is complete
          fin      = 1'b1;
          state_nx = S_IDLE;
        end else if (link_start) begin
          state_nx = S_XFER;
        end else if (wd_hit) begin
          abort    = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_XFER: begin
        if (link_done) begin
          fin      = 1'b1;
          state_nx = S_IDLE;
        end else if (wd_hit && !link_rd) begin
          abort    = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gidx      <= '0;
      grant     <= '0;
      link_len  <= '0;
      link_port <= '0;
      done      <= '0;
      err       <= 1'b0;
      frame_cnt <= '0;
      wd        <= '0;
    end else begin
      state <= state_nx;
      done  <= '0;
      err   <= 1'b0;
      if (state_nx != state || state == S_IDLE || link_rd) wd <= '0;
      else                                                 wd <= wd + 32'd1;
      if (take) begin
        grant     <= pick_win;
        gidx      <= pick_idx;
        link_len  <= sel_len;
        link_port <= sel_port;
      end
      if (fin || abort || zdone) begin
        done  <= grant;
        grant <= '0;
        ptr   <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
      if (fin)   frame_cnt <= frame_cnt + 32'd1;
      if (abort) err       <= 1'b1;
    end
  end

  assign link_req = (state == S_REQ) && (link_len != '0);
  assign rd       = (state == S_XFER) ? (grant & {NREQ{link_rd}}) : '0;

  always_comb begin
    link_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) link_data = link_data | req_data[i*8 +: 8];
  end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
module tb_udp_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int LENW    = 16;
  localparam int TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ*16-1:0]   req_port;
  logic [NREQ*8-1:0]    req_data;
  logic [NREQ-1:0]      rd, done, grant;
  logic                 link_req, link_start, link_rd, link_done, err;
  logic [LENW-1:0]      link_len;
  logic [15:0]          link_port;
  logic [7:0]           link_data;
  logic [31:0]          frame_cnt;

  udp_tx_arbiter #(.NREQ(NREQ), .LENW(LENW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len), .req_port(req_port),
    .req_data(req_data), .rd(rd), .done(done), .grant(grant), .link_req(link_req),
    .link_len(link_len), .link_port(link_port), .link_start(link_start),
    .link_rd(link_rd), .link_data(link_data), .link_done(link_done), .err(err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int mptr = 0, mcnt = 0, mdone = 0, merr = 0;
  int ndone = 0, nerr = 0;
  int bcnt [NREQ];
  int seed [NREQ];

  // Requester byte source: byte n of requester i is a fixed hash; n counts
  // the rd strobes that requester has received.
  function automatic logic [7:0] data_of(input int i, input int n, input int s);
    return 8'(s + n * 37 + i * 11);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (reset) bcnt[i] <= 0;
      else if (rd[i]) bcnt[i] <= bcnt[i] + 1;
  end

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = data_of(i, bcnt[i], seed[i]);
  end

  always @(negedge clk) begin
    ndone += $countones(done);
    if (err === 1'b1) nerr++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Winner per the rule: first requester at or after ptr, wrapping.
  function automatic int exp_win(input logic [NREQ-1:0] r, input int p);
    for (int o = 0; o < NREQ; o++)
      if (r[(p + o) % NREQ]) return (p + o) % NREQ;
    return -1;
  endfunction

  task automatic post(input int i, input int len, input logic [15:0] port);
    req[i]                 = 1'b1;
    req_len[i*LENW +: LENW] = LENW'(len);
    req_port[i*16 +: 16]    = port;
    seed[i]                 = int'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; link_start = 0; link_rd = 0; link_done = 0;
    step(); step();
    reset = 1'b0;
    mptr = 0; mcnt = 0;
  endtask

  // One arbitration + frame. mode 0: normal, 1: stall until watchdog,
  // 2: link_start and link_done together. Caller is in an idle cycle.
  task automatic frame(input int mode, input int dly, output int w);
    int len, base, n;
    step();
    w = exp_win(req, mptr);
    if (w < 0) begin
      chk("grant_none", 64'(grant), 0);
      return;
    end
    chk("grant", 64'(grant), 64'(1) << w);
    len = int'(req_len[w*LENW +: LENW]);
    chk("link_len", 64'(link_len), 64'(len));
    chk("link_port", 64'(link_port), 64'(req_port[w*16 +: 16]));
    mptr = (w + 1) % NREQ;
    if (len == 0) begin
      chk("zl_link_req", 64'(link_req), 0);
      step();
      mdone++;
      chk("zl_link_req2", 64'(link_req), 0);
      chk("zl_done", 64'(done), 64'(1) << w);
      chk("zl_cnt", 64'(frame_cnt), 64'(mcnt));
      return;
    end
    chk("link_req", 64'(link_req), 1);
    repeat (dly) begin
      step();
      chk("link_req_hold", 64'(link_req), 1);
    end
    link_start = 1'b1;
    if (mode == 2) begin
      link_done = 1'b1;
      step();
      link_start = 0; link_done = 0;
      mcnt++; mdone++;
      chk("sd_done", 64'(done), 64'(1) << w);
      chk("sd_cnt", 64'(frame_cnt), 64'(mcnt));
      return;
    end
    step();
    link_start = 1'b0;
    chk("xfer_link_req", 64'(link_req), 0);
    if (mode == 1) begin
      n = 0;
      while (err !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      mdone++; merr++;
      chk("wd_cycles", 64'(n), 64'(TIMEOUT));
      chk("wd_done", 64'(done), 64'(1) << w);
      chk("wd_cnt", 64'(frame_cnt), 64'(mcnt));
      chk("wd_grant", 64'(grant), 0);
      return;
    end
    base = bcnt[w];
    for (int k = 0; k < len; k++) begin
      repeat ($urandom_range(0, 2)) step();
      link_rd = 1'b1;
      #1;
      chk("rd", 64'(rd), 64'(1) << w);
      step();
      link_rd = 1'b0;
      #1;
      chk("data", 64'(link_data), 64'(data_of(w, base + k + 1, seed[w])));
    end
    link_done = 1'b1;
    step();
    link_done = 1'b0;
    mcnt++; mdone++;
    chk("done", 64'(done), 64'(1) << w);
    chk("cnt", 64'(frame_cnt), 64'(mcnt));
    chk("grant_clr", 64'(grant), 0);
    chk("no_err", 64'(err), 0);
  endtask

  initial begin
    int w, prev, mode, j;
    req = '0; req_len = '0; req_port = '0;
    for (int i = 0; i < NREQ; i++) seed[i] = 0;
    link_start = 0; link_rd = 0; link_done = 0; reset = 1'b1;
    do_reset();

    chk("rst_grant", 64'(grant), 0);
    chk("rst_link_req", 64'(link_req), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_rd", 64'(rd), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_cnt", 64'(frame_cnt), 0);
    chk("rst_len", 64'(link_len), 0);
    chk("rst_port", 64'(link_port), 0);
    chk("rst_data", 64'(link_data), 0);

    // single frame
    post(1, 4, 16'hd001);
    frame(0, 3, w);
    chk("sf_winner", 64'(w), 1);
    chk("sf_cnt", 64'(frame_cnt), 1);
    req = '0;

    // round robin, everyone holding req
    do_reset();
    for (int i = 0; i < NREQ; i++) post(i, 2, 16'(16'h1000 + i));
    for (int f = 0; f < 5; f++) begin
      frame(0, $urandom_range(0, 2), w);
      chk("rr_order", 64'(w), 64'(f % NREQ));
    end
    chk("rr_cnt", 64'(frame_cnt), 5);
    req = '0;

    // priority rotation between 0 and 2
    post(0, 2, 16'h2000);
    post(2, 2, 16'h2002);
    prev = -1;
    for (int f = 0; f < 4; f++) begin
      frame(0, 0, w);
      chk("prio_alt", 64'(w != prev), 1);
      prev = w;
    end
    req = '0;

    // zero length
    post(3, 0, 16'h3003);
    frame(0, 0, w);
    chk("zl_winner", 64'(w), 3);

    // watchdog, then the next requester gets served
    req = '0;
    post(1, 3, 16'h4001);
    post(2, 3, 16'h4002);
    frame(1, 1, w);
    req[w] = 1'b0;
    frame(0, 0, w);
    req = '0;

    // start and done in the same cycle
    post(0, 2, 16'h5000);
    frame(2, 0, w);
    req = '0;

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 1) == 1)
          post(i, $urandom_range(0, 6), 16'($urandom));
      if (req == '0) post($urandom_range(0, NREQ - 1), $urandom_range(1, 6), 16'($urandom));
      mode = ($urandom_range(0, 7) == 0) ? 1 : (($urandom_range(0, 7) == 0) ? 2 : 0);
      frame(mode, $urandom_range(0, 3), w);
      if (w >= 0 && $urandom_range(0, 3) != 0) req[w] = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
        j = $urandom_range(0, NREQ - 1);
        if (j != w) req[j] = 1'b0;
      end
    end
    req = '0;
    step();

    // reset in the middle of a transfer
    post(1, 4, 16'h6001);
    step();
    link_start = 1'b1;
    step();
    link_start = 1'b0;
    link_rd = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("mr_grant", 64'(grant), 0);
    chk("mr_link_req", 64'(link_req), 0);
    chk("mr_rd", 64'(rd), 0);
    chk("mr_done", 64'(done), 0);
    chk("mr_err", 64'(err), 0);
    chk("mr_cnt", 64'(frame_cnt), 0);
    reset = 1'b0;
    link_rd = 1'b0;
    mptr = 0; mcnt = 0;
    post(2, 2, 16'h6002);
    frame(0, 0, w);
    chk("mr_restart", 64'(w), 1);
    req = '0;
    step();

    chk("done_pulses", 64'(ndone), 64'(mdone));
    chk("err_pulses", 64'(nerr), 64'(merr));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
